// File: rtl/decode_stage.sv
// decode_stage: registered, valid/ready handshaked decode stage for the
// single-issue MIPS-subset CPU. It splits the instruction into fields,
// extends the immediate, generates control signals and precomputes the
// branch and jump targets. Everything is presented one cycle after capture.
module decode_stage #(
    parameter int DATA_WIDTH = 32,
    parameter int PC_WIDTH   = 32,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [31:0]           instruction,
    input  logic [PC_WIDTH-1:0]   pc,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [5:0]            op_code,
    output logic [5:0]            func,
    output logic [4:0]            rs,
    output logic [4:0]            rt,
    output logic [4:0]            rd,
    output logic [4:0]            shift,
    output logic [25:0]           target,
    output logic [DATA_WIDTH-1:0] imm_ext,
    output logic [1:0]            itype,
    output logic                  reg_write,
    output logic                  mem_read,
    output logic                  mem_write,
    output logic                  is_branch,
    output logic                  is_jump,
    output logic                  link,
    output logic                  alu_src_imm,
    output logic                  illegal,
    output logic [PC_WIDTH-1:0]   branch_target,
    output logic [PC_WIDTH-1:0]   jump_target,
    output logic [CNT_WIDTH-1:0]  decode_count
);

    // Opcode and function encodings of the supported subset
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;

    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_SUB   = 6'h22;
    localparam logic [5:0] FN_SLT   = 6'h2A;
    localparam logic [5:0] FN_JR    = 6'h08;

    localparam logic [1:0] IT_R       = 2'd0;
    localparam logic [1:0] IT_I       = 2'd1;
    localparam logic [1:0] IT_J       = 2'd2;
    localparam logic [1:0] IT_ILLEGAL = 2'd3;

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};
    // Jump target keeps the region bits of pc+4 above bit 27
    localparam logic [PC_WIDTH-1:0]  LOW28_MASK = PC_WIDTH'(28'hFFF_FFFF);

    // Elaboration-time parameter sanity
    if (DATA_WIDTH < 16) begin : g_bad_data_width
        $error("decode_stage: DATA_WIDTH must be at least 16");
    end
    if (PC_WIDTH < 28) begin : g_bad_pc_width
        $error("decode_stage: PC_WIDTH must be at least 28");
    end

    // Control bundle kept together so the decode table stays readable
    typedef struct packed {
        logic [1:0] itype;
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic       is_branch;
        logic       is_jump;
        logic       link;
        logic       alu_src_imm;
        logic       illegal;
    } ctrl_t;

    // Control word for one instruction; illegal encodings carry no side effects
    function automatic ctrl_t decode_ctrl(input logic [5:0] op, input logic [5:0] fn);
        ctrl_t c;
        c = '{itype: IT_ILLEGAL, illegal: 1'b1, default: 1'b0};
        case (op)
            OP_RTYPE: begin
                case (fn)
                    FN_ADD, FN_SUB, FN_SLT: begin
                        c = '{itype: IT_R, reg_write: 1'b1, default: 1'b0};
                    end
                    FN_JR: begin
                        c = '{itype: IT_R, is_jump: 1'b1, default: 1'b0};
                    end
                    default: begin
                        c = '{itype: IT_ILLEGAL, illegal: 1'b1, default: 1'b0};
                    end
                endcase
            end
            OP_LW: begin
                c = '{itype: IT_I, reg_write: 1'b1, mem_read: 1'b1, alu_src_imm: 1'b1, default: 1'b0};
            end
            OP_SW: begin
                c = '{itype: IT_I, mem_write: 1'b1, alu_src_imm: 1'b1, default: 1'b0};
            end
            OP_BNE: begin
                c = '{itype: IT_I, is_branch: 1'b1, default: 1'b0};
            end
            OP_ADDI, OP_XORI: begin
                c = '{itype: IT_I, reg_write: 1'b1, alu_src_imm: 1'b1, default: 1'b0};
            end
            OP_J: begin
                c = '{itype: IT_J, is_jump: 1'b1, default: 1'b0};
            end
            OP_JAL: begin
                c = '{itype: IT_J, is_jump: 1'b1, link: 1'b1, reg_write: 1'b1, default: 1'b0};
            end
            default: begin
                c = '{itype: IT_ILLEGAL, illegal: 1'b1, default: 1'b0};
            end
        endcase
        return c;
    endfunction

    // XORI is the only logical immediate, so it alone zero-extends
    function automatic logic [DATA_WIDTH-1:0] extend_imm(input logic [5:0] op, input logic [15:0] imm);
        logic [DATA_WIDTH-1:0] r;
        if (op == OP_XORI) begin
            r = DATA_WIDTH'(imm);
        end else begin
            r = DATA_WIDTH'(signed'(imm));
        end
        return r;
    endfunction

    // Registered state
    logic                  out_valid_r;
    logic [5:0]            op_code_r;
    logic [5:0]            func_r;
    logic [4:0]            rs_r;
    logic [4:0]            rt_r;
    logic [4:0]            rd_r;
    logic [4:0]            shift_r;
    logic [25:0]           target_r;
    logic [DATA_WIDTH-1:0] imm_ext_r;
    ctrl_t                 ctrl_r;
    logic [PC_WIDTH-1:0]   branch_target_r;
    logic [PC_WIDTH-1:0]   jump_target_r;
    logic [CNT_WIDTH-1:0]  decode_count_r;

    // Next-entry values computed from the incoming instruction
    ctrl_t                 ctrl_s;
    logic [DATA_WIDTH-1:0] imm_ext_s;
    logic [PC_WIDTH-1:0]   pc_plus4_s;
    logic [PC_WIDTH-1:0]   branch_target_s;
    logic [PC_WIDTH-1:0]   jump_target_s;
    logic                  in_ready_s;
    logic                  in_xfer_s;
    logic                  out_xfer_s;

    // Handshake: the slot is free when empty or being drained this cycle
    always_comb begin
        in_ready_s = !out_valid_r || out_ready;
        in_xfer_s  = in_valid && in_ready_s && !flush;
        out_xfer_s = out_valid_r && out_ready;
    end

    // Decode the incoming instruction and precompute both targets
    always_comb begin
        ctrl_s          = decode_ctrl(instruction[31:26], instruction[5:0]);
        imm_ext_s       = extend_imm(instruction[31:26], instruction[15:0]);
        pc_plus4_s      = pc + PC_WIDTH'(32'd4);
        branch_target_s = pc_plus4_s + PC_WIDTH'({imm_ext_s, 2'b00});
        jump_target_s   = (pc_plus4_s & ~LOW28_MASK) | PC_WIDTH'({instruction[25:0], 2'b00});
    end

    // Pipeline register: reset beats flush, flush beats capture, capture beats drain
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_r     <= 1'b0;
            op_code_r       <= 6'd0;
            func_r          <= 6'd0;
            rs_r            <= 5'd0;
            rt_r            <= 5'd0;
            rd_r            <= 5'd0;
            shift_r         <= 5'd0;
            target_r        <= 26'd0;
            imm_ext_r       <= {DATA_WIDTH{1'b0}};
            ctrl_r          <= '{itype: IT_R, default: 1'b0};
            branch_target_r <= {PC_WIDTH{1'b0}};
            jump_target_r   <= {PC_WIDTH{1'b0}};
        end else if (flush) begin
            out_valid_r <= 1'b0;
        end else if (in_xfer_s) begin
            out_valid_r     <= 1'b1;
            op_code_r       <= instruction[31:26];
            func_r          <= instruction[5:0];
            rs_r            <= instruction[25:21];
            rt_r            <= instruction[20:16];
            rd_r            <= instruction[15:11];
            shift_r         <= instruction[10:6];
            target_r        <= instruction[25:0];
            imm_ext_r       <= imm_ext_s;
            ctrl_r          <= ctrl_s;
            branch_target_r <= branch_target_s;
            jump_target_r   <= jump_target_s;
        end else if (out_xfer_s) begin
            out_valid_r <= 1'b0;
        end else begin
            out_valid_r <= out_valid_r;
        end
    end

    // Saturating count of completed output transfers (flush does not cancel them)
    always_ff @(posedge clk) begin
        if (reset) begin
            decode_count_r <= {CNT_WIDTH{1'b0}};
        end else if (out_xfer_s && (decode_count_r != CNT_MAX)) begin
            decode_count_r <= decode_count_r + CNT_WIDTH'(1'b1);
        end else begin
            decode_count_r <= decode_count_r;
        end
    end

    assign in_ready      = in_ready_s;
    assign out_valid     = out_valid_r;
    assign op_code       = op_code_r;
    assign func          = func_r;
    assign rs            = rs_r;
    assign rt            = rt_r;
    assign rd            = rd_r;
    assign shift         = shift_r;
    assign target        = target_r;
    assign imm_ext       = imm_ext_r;
    assign itype         = ctrl_r.itype;
    assign reg_write     = ctrl_r.reg_write;
    assign mem_read      = ctrl_r.mem_read;
    assign mem_write     = ctrl_r.mem_write;
    assign is_branch     = ctrl_r.is_branch;
    assign is_jump       = ctrl_r.is_jump;
    assign link          = ctrl_r.link;
    assign alu_src_imm   = ctrl_r.alu_src_imm;
    assign illegal       = ctrl_r.illegal;
    assign branch_target = branch_target_r;
    assign jump_target   = jump_target_r;
    assign decode_count  = decode_count_r;

endmodule
